// File: rtl/paddle_driver.sv
// rtl/paddle_driver.sv - button synchroniser/debouncer and rate-limited paddle position stepper
module paddle_driver #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP_DIV        = 500000,
  parameter int STEP            = 4,
  parameter int Y_MIN           = 20,
  parameter int Y_MAX           = 460,
  parameter int BAT_SMALL       = 60,
  parameter int BAT_LARGE       = 100,
  parameter int P1_INIT         = 210,
  parameter int P2_INIT         = 210
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p1_up,
  input  logic        p1_dn,
  input  logic        p2_up,
  input  logic        p2_dn,
  input  logic        bat_size,
  input  logic        freeze,
  output logic [10:0] p1_y,
  output logic [10:0] p2_y,
  output logic        tick
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(STEP_DIV + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);
  localparam logic [11:0]   STEP_W    = 12'(STEP);
  localparam logic [11:0]   Y_MIN_W   = 12'(Y_MIN);
  localparam logic [10:0]   LIM_SMALL = 11'(Y_MAX - BAT_SMALL);
  localparam logic [10:0]   LIM_LARGE = 11'(Y_MAX - BAT_LARGE);

  // Bit order everywhere: {p2_dn, p2_up, p1_dn, p1_up}
  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    db;
  logic [DW-1:0] db_cnt [4];
  logic [TW-1:0] tick_cnt;
  logic [10:0]   lim;
  logic [10:0]   p1_next;
  logic [10:0]   p2_next;

  assign raw = {p2_dn, p2_up, p1_dn, p1_up};

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after it has differed from the
  // debounced state for DEBOUNCE_CYCLES consecutive cycles; any return to
  // the old level (the only possible change of a 1-bit input) restarts it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Free-running movement rate counter; freeze does not stop it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);
  assign lim  = bat_size ? LIM_LARGE : LIM_SMALL;

  // Clamp beats freeze beats movement; opposing buttons cancel out
  function automatic logic [10:0] step_y(input logic [10:0] y, input logic up,
                                         input logic dn, input logic [10:0] limit,
                                         input logic tk, input logic frz);
    logic signed [11:0] dec;
    logic [11:0]        inc;
    dec    = $signed({1'b0, y}) - $signed(STEP_W);
    inc    = {1'b0, y} + STEP_W;
    step_y = y;
    if (y > limit) begin
      step_y = limit;
    end else if (frz) begin
      step_y = y;
    end else if (tk && up && !dn) begin
      step_y = (dec < $signed(Y_MIN_W)) ? Y_MIN_W[10:0] : dec[10:0];
    end else if (tk && dn && !up) begin
      step_y = (inc > {1'b0, limit}) ? limit : inc[10:0];
    end
  endfunction

  // Next paddle positions from the debounced buttons
  always_comb begin
    p1_next = step_y(p1_y, db[0], db[1], lim, tick, freeze);
    p2_next = step_y(p2_y, db[2], db[3], lim, tick, freeze);
  end

  // Paddle position registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_y <= 11'(P1_INIT);
      p2_y <= 11'(P2_INIT);
    end else begin
      p1_y <= p1_next;
      p2_y <= p2_next;
    end
  end

endmodule
